addsub_serial: RTL

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_serial.sv | 129 ++++++++++++
 1 files changed

// File: rtl/addsub_serial.sv
// ============================================================================
// Module   : addsub_serial
// Brief    : Bit-serial unsigned add/subtract, one result bit per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_serial #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               MODE,
    input  logic [WIDTH-1:0]   A_DATA,
    input  logic [WIDTH-1:0]   B_DATA,
    output logic               BUSY,
    output logic               DONE,
    output logic [WIDTH+1:0]   RES_DATA,
    output logic               NEG
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   bit_sel;
    logic               mode_q;
    logic               carry;
    logic               done_q;
    logic [WIDTH+1:0]   res_q;

    logic               last_bit;
    logic               a_bit;
    logic               b_bit;
    logic               sum_bit;
    logic               carry_out;

    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign a_bit     = a_sh[0];
    // Subtraction is A + ~B + 1; the +1 enters through the carry loaded with MODE.
    assign b_bit     = b_sh[0] ^ mode_q;
    assign sum_bit   = a_bit ^ b_bit ^ carry;
    assign carry_out = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = RUN;
            RUN:     if (last_bit) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            bit_sel <= '0;
            mode_q  <= 1'b0;
            carry   <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            // The result is announced the cycle after FIN so it is stable for a full cycle.
            done_q <= (state == FIN);
            case (state)
                IDLE: begin
                    if (START) begin
                        a_sh    <= A_DATA;
                        b_sh    <= B_DATA;
                        mode_q  <= MODE;
                        carry   <= MODE;
                        bit_cnt <= '0;
                        bit_sel <= WIDTH'(1);
                    end
                end
                RUN: begin
                    if (sum_bit) begin
                        res_q[WIDTH-1:0] <= res_q[WIDTH-1:0] | bit_sel;
                    end else begin
                        res_q[WIDTH-1:0] <= res_q[WIDTH-1:0] & ~bit_sel;
                    end
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    bit_sel <= bit_sel << 1;
                    carry   <= carry_out;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        if (mode_q) begin
                            // No borrow out means A >= B; otherwise sign-extend negative.
                            res_q[WIDTH+1:WIDTH] <= carry_out ? 2'b00 : 2'b11;
                        end else begin
                            res_q[WIDTH+1:WIDTH] <= {1'b0, carry_out};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY     = (state == RUN) || (state == FIN);
    assign DONE     = done_q;
    assign RES_DATA = res_q;
    assign NEG      = res_q[WIDTH+1];

endmodule

`default_nettype wire
